// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-specifier width, hazard FSM encodings, NOP opcode.
package cpu_pkg;

  localparam int REG_W = 5;

  // Opcode loaded into a pipeline register when it takes a bubble.
  localparam logic [5:0] OP_NOP = 6'd0;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_RAW = 2'd1,
    ST_MEM = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID source specifier against the EX and MEM shadow entries; purely combinational.
module hazard_cmp
  import cpu_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         i_use,
  input  logic [W-1:0] i_src,
  input  logic         i_ex_v,
  input  logic [W-1:0] i_ex_reg,
  input  logic         i_mem_v,
  input  logic [W-1:0] i_mem_reg,
  output logic         o_hit
);

  logic w_match;

  // r0 is hard-wired zero, so it can never carry a dependency.
  assign w_match = (i_ex_v && (i_ex_reg == i_src)) || (i_mem_v && (i_mem_reg == i_src));
  assign o_hit   = i_use && (i_src != '0) && w_match;

endmodule

// File: rtl/hazard_ctrl.sv
// RAW/branch/memory-wait hazard controller; controls are combinational (zero latency),
// shadow pipeline, state and stall counter update on the next edge.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [REG_W-1:0] Ri_id,
  input  logic             wr_id,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  logic             r_ex_v;
  logic [REG_W-1:0] r_ex_reg;
  logic             r_mem_v;
  logic [REG_W-1:0] r_mem_reg;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_hit_rs;
  logic w_hit_rt;
  logic w_raw;
  logic w_raw_stall;
  logic w_squash;

  hazard_cmp #(.W(REG_W)) u_cmp_rs (
    .i_use     (use_rs_id),
    .i_src     (rs_id),
    .i_ex_v    (r_ex_v),
    .i_ex_reg  (r_ex_reg),
    .i_mem_v   (r_mem_v),
    .i_mem_reg (r_mem_reg),
    .o_hit     (w_hit_rs)
  );

  hazard_cmp #(.W(REG_W)) u_cmp_rt (
    .i_use     (use_rt_id),
    .i_src     (rt_id),
    .i_ex_v    (r_ex_v),
    .i_ex_reg  (r_ex_reg),
    .i_mem_v   (r_mem_v),
    .i_mem_reg (r_mem_reg),
    .o_hit     (w_hit_rt)
  );

  // A frozen pipeline defers both the branch flush and the RAW decision.
  assign w_raw       = w_hit_rs || w_hit_rt;
  assign w_raw_stall = !mem_busy && !branch_taken_ex && w_raw;
  assign w_squash    = !mem_busy && (branch_taken_ex || w_raw);

  assign pc_stall     = !rst && (mem_busy || w_raw_stall);
  assign ifid_stall   = !rst && (mem_busy || w_raw_stall);
  assign ifid_flush   = !rst && !mem_busy && branch_taken_ex;
  assign idex_hold    = !rst && mem_busy;
  assign idex_bubble  = !rst && w_squash;
  assign exmem_hold   = !rst && mem_busy;
  assign memwb_bubble = !rst && mem_busy;

  assign stall_count = r_cnt;
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_ex_v    <= 1'b0;
      r_ex_reg  <= '0;
      r_mem_v   <= 1'b0;
      r_mem_reg <= '0;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, pc_stall};
      if (mem_busy) begin
        r_state <= ST_MEM;
      end else begin
        r_mem_v   <= r_ex_v;
        r_mem_reg <= r_ex_reg;
        // A squashed or stalled ID instruction does not enter EX.
        r_ex_v    <= !w_squash && wr_id && (Ri_id != '0);
        r_ex_reg  <= Ri_id;
        r_state   <= w_raw_stall ? ST_RAW : ST_RUN;
      end
    end
  end

endmodule
